rr_arbiter_8: RTL and testbench
===============================

// Module: rr_arbiter_8
// PURPOSE
//   Round-robin arbiter placed directly upstream of the 8-to-3 one-hot encoder.
//   Takes up to N request lines and registers a strictly one-hot grant vector.
//   grant drives the encoder's d input; grant_valid drives its enable input.
//   A grant is held until the holder signals done, drops its request, or hits a hold timeout.
// PARAMETERS
//   N         8   number of requesters; legal range 2..8, so the encoder input width is never exceeded
//   MAX_HOLD  16  max cycles a grant is held; 0 disables the timeout
// PORTS
//   clk          in   1   single clock; all state updates on the rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   req          in   N   request per requester; level-sensitive, held while waiting
//   done         in   1   current holder releases its grant; sampled only in GRANT
//   grant        out  N   registered grant; one-hot in GRANT, all-zero otherwise
//   grant_valid  out  1   registered; high exactly while grant is non-zero
//   timeout      out  1   registered one-cycle pulse when a grant is force-released
// BEHAVIOUR
//   Reset (rst_n=0, async): clears all state immediately, including mid-grant.
//     state=IDLE, grant=0, grant_valid=0, timeout=0, ptr=0, hold_cnt=0.
//   ptr: $clog2(N) bits; lowest index with priority in the next search.
//   hold_cnt: $clog2(MAX_HOLD+1) bits, wide enough for all values 0..MAX_HOLD.
//   State IDLE:
//     - If req==0: stay in IDLE, outputs remain 0.
//     - Else pick winner w = first set bit of req scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
//     - Next edge: grant=1<<w, grant_valid=1, hold_cnt=0, state=GRANT.
//     - Latency: req sampled high at edge k -> grant visible after edge k.
//   State GRANT (holder index w):
//     - Release when any of these holds at an edge:
//       (a) done=1
//       (b) req[w]=0
//       (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
//     - On release: grant=0, grant_valid=0, ptr=(w+1) mod N, hold_cnt=0, state=IDLE.
//     - On a release caused only by (c): timeout=1 for that one cycle.
//     - Otherwise: hold_cnt increments and grant stays unchanged.
//       Changes on other req bits are ignored; there is no preemption.
//   Bubble: every release is followed by at least one cycle with grant_valid=0.
//     Back-to-back grants are therefore spaced by at least 1 idle cycle.
//     The downstream encoder then outputs 0 during the bubble.
//   Simultaneous events:
//     - done together with (c): normal release, no timeout pulse.
//     - done together with req[w]=0: single release.
//     - done while in IDLE: ignored.
//   Wrap-around: ptr wraps N-1 -> 0. Search order is circular with no starvation.
//     Any held request is granted within N grants.
//   Invariants (assert in bench):
//     - $onehot0(grant) at all times.
//     - grant_valid == |grant.
//     - grant & ~req may be non-zero for at most the single cycle before a (b) release.
//     - timeout implies grant_valid==0 in the same cycle.
// TESTING
//   1 Reset: drive rst_n=0 mid-grant (grant=8'h04)
//     -> grant=0, grant_valid=0, timeout=0 immediately without a clock edge
//     -> first grant after reset follows ptr=0.
//   2 Single request: req=8'h01, pulse done after 3 cycles
//     -> grant=8'h01 one edge after req, held 3 cycles
//     -> grant=0 after the done edge, then re-granted 8'h01 after the bubble.
//   3 Rotation: req=8'hFF held, done pulsed each GRANT cycle
//     -> grants 01,02,04,08,10,20,40,80,01, each separated by one idle cycle.
//   4 Wrap: grant bit 3 then release (ptr=4), then req=8'h09
//     -> next grant=8'h01 (search 4..7 finds nothing, wraps to 0).
//     Then done -> next grant=8'h08.
//   5 Timeout, MAX_HOLD=4: req=8'h06 held, done never asserted
//     -> 8'h02 held 4 cycles, timeout=1 for one cycle, bubble, then grant=8'h04.
//     Same run with done on the 4th cycle -> no timeout pulse.
//   6 Requester drop: grant=8'h10 active, deassert req[4]
//     -> grant=0 on the next edge, ptr=5, no timeout pulse.
//     Encoder downstream reads y=4 during the grant, y=0 after release.

Source files
------------

// File: rtl/rr_arbiter_8_if.sv
//------------------------------------------------------------------------------
// Module      : rr_arbiter_8_if
// Description : Request/grant bundle between requesters and rr_arbiter_8.
//               master modport : requester side (drives req/done)
//               slave modport  : arbiter side (drives grant/grant_valid/timeout)
//   req          N   level request per requester, held while waiting
//   done         1   current holder releases its grant
//   grant        N   registered one-hot grant (all-zero when idle)
//   grant_valid  1   high exactly while grant is non-zero
//   timeout      1   one-cycle pulse when a grant is force-released
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rr_arbiter_8_if #(
  parameter int N = 8
);
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic         timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_valid,
    output timeout
  );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter_8.sv
//------------------------------------------------------------------------------
// Module      : rr_arbiter_8
// Description : Round-robin arbiter feeding an 8-to-3 one-hot encoder.
//               Registers a strictly one-hot grant; the grant is held until
//               the holder asserts done, drops its request, or the hold
//               timeout expires. Every release is followed by at least one
//               idle cycle (grant_valid=0).
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of rr_arbiter_8_if:
//            req/done in, grant/grant_valid/timeout out (all registered)
//   N        number of requesters, 2..8
//   MAX_HOLD maximum grant length in cycles, 0 disables the timeout
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_8 #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  rr_arbiter_8_if.slave  bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  // MAX_HOLD=0 would give a zero-width counter; keep one bit, it is unused.
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [PW-1:0] c_ptr_last   = PW'(N - 1);
  localparam logic [HW-1:0] c_hold_last  = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic          c_timeout_en = (MAX_HOLD != 0);
  localparam logic [PW:0]   c_n_ext      = (PW + 1)'(N);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          r_state,       w_state_nxt;
  logic [N-1:0]    r_grant,       w_grant_nxt;
  logic            r_grant_valid, w_grant_valid_nxt;
  logic            r_timeout,     w_timeout_nxt;
  logic [PW-1:0]   r_ptr,         w_ptr_nxt;
  logic [HW-1:0]   r_hold_cnt,    w_hold_cnt_nxt;
  logic [PW-1:0]   r_idx,         w_idx_nxt;

  logic [PW-1:0]   w_win;
  logic            w_found;
  logic [PW:0]     w_sum;
  logic [PW-1:0]   w_cand;

  logic            w_rel_done;
  logic            w_rel_drop;
  logic            w_rel_hold;
  logic            w_release;

  // Circular priority search starting at r_ptr; first requester found wins.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, r_ptr} + (PW + 1)'(i);
      if (w_sum >= c_n_ext) begin
        w_sum = w_sum - c_n_ext;
      end
      w_cand = w_sum[PW-1:0];
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Release causes for the current holder r_idx.
  assign w_rel_done = bus.done;
  assign w_rel_drop = ~bus.req[r_idx];
  assign w_rel_hold = c_timeout_en && (r_hold_cnt == c_hold_last);
  assign w_release  = w_rel_done | w_rel_drop | w_rel_hold;

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_grant_valid_nxt = r_grant_valid;
    w_timeout_nxt     = 1'b0;
    w_ptr_nxt         = r_ptr;
    w_hold_cnt_nxt    = r_hold_cnt;
    w_idx_nxt         = r_idx;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt       = N'(1) << w_win;
          w_grant_valid_nxt = 1'b1;
          w_hold_cnt_nxt    = '0;
          w_idx_nxt         = w_win;
          w_state_nxt       = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (w_release) begin
          w_grant_nxt       = '0;
          w_grant_valid_nxt = 1'b0;
          w_hold_cnt_nxt    = '0;
          w_ptr_nxt         = (r_idx == c_ptr_last) ? '0 : r_idx + 1'b1;
          w_state_nxt       = ST_IDLE;
          // Pulse only when the timeout is the sole reason for release.
          w_timeout_nxt     = w_rel_hold & ~w_rel_done & ~w_rel_drop;
        end else begin
          w_hold_cnt_nxt    = r_hold_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt       = ST_IDLE;
        w_grant_nxt       = '0;
        w_grant_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_ptr         <= '0;
      r_hold_cnt    <= '0;
      r_idx         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_timeout     <= w_timeout_nxt;
      r_ptr         <= w_ptr_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_idx         <= w_idx_nxt;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = r_grant_valid;
  assign bus.timeout     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
//------------------------------------------------------------------------------
// Module      : tb_rr_arbiter_8
// Description : Directed self-checking bench for rr_arbiter_8.
//               dut_a uses MAX_HOLD=16, dut_b uses MAX_HOLD=4 for timeouts.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rr_arbiter_8;

  logic clk;
  logic rst_n;

  int n_chk;
  int n_err;

  rr_arbiter_8_if #(.N(8)) ifa ();
  rr_arbiter_8_if #(.N(8)) ifb ();

  rr_arbiter_8 #(.N(8), .MAX_HOLD(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  rr_arbiter_8 #(.N(8), .MAX_HOLD(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rot [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                          8'h20, 8'h40, 8'h80, 8'h01};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Downstream 8-to-3 one-hot encoder model.
  function automatic logic [7:0] enc(input logic [7:0] g);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      if (g[i]) y = 8'(i);
    end
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants sampled mid-cycle on both instances.
  logic a_drop_prev = 1'b0;
  logic b_drop_prev = 1'b0;

  always @(negedge clk) begin
    chk("inv_a_onehot", {7'b0, $onehot0(ifa.grant)}, 8'h01);
    chk("inv_a_valid",  {7'b0, ifa.grant_valid}, {7'b0, |ifa.grant});
    chk("inv_a_to",     {7'b0, ifa.timeout & ifa.grant_valid}, 8'h00);
    chk("inv_b_onehot", {7'b0, $onehot0(ifb.grant)}, 8'h01);
    chk("inv_b_valid",  {7'b0, ifb.grant_valid}, {7'b0, |ifb.grant});
    chk("inv_b_to",     {7'b0, ifb.timeout & ifb.grant_valid}, 8'h00);
    if (a_drop_prev && rst_n) chk("inv_a_drop", ifa.grant, 8'h00);
    if (b_drop_prev && rst_n) chk("inv_b_drop", ifb.grant, 8'h00);
    a_drop_prev <= |(ifa.grant & ~ifa.req);
    b_drop_prev <= |(ifb.grant & ~ifb.req);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n    = 1'b0;
    ifa.req  = 8'h00;
    ifa.done = 1'b0;
    ifb.req  = 8'h00;
    ifb.done = 1'b0;

    tick();
    tick();
    chk("rst_a_grant", ifa.grant, 8'h00);
    chk("rst_a_valid", {7'b0, ifa.grant_valid}, 8'h00);
    chk("rst_a_to",    {7'b0, ifa.timeout}, 8'h00);
    chk("rst_b_grant", ifb.grant, 8'h00);
    rst_n = 1'b1;

    // Reset mid-grant with ptr moved away from 0.
    ifa.req = 8'h02;
    tick();
    chk("t1_g02", ifa.grant, 8'h02);
    chk("t1_valid", {7'b0, ifa.grant_valid}, 8'h01);
    ifa.done = 1'b1;
    tick();
    chk("t1_rel", ifa.grant, 8'h00);
    ifa.done = 1'b0;
    ifa.req  = 8'h04;
    tick();
    chk("t1_g04", ifa.grant, 8'h04);
    #3 rst_n = 1'b0;
    #1;
    chk("t1_async_grant", ifa.grant, 8'h00);
    chk("t1_async_valid", {7'b0, ifa.grant_valid}, 8'h00);
    chk("t1_async_to",    {7'b0, ifa.timeout}, 8'h00);
    tick();
    rst_n   = 1'b1;
    ifa.req = 8'h06;
    tick();
    chk("t1_ptr0", ifa.grant, 8'h02);

    // Single requester, done after 3 grant cycles.
    ifa.req = 8'h00;
    tick();
    chk("t2_drop", ifa.grant, 8'h00);
    ifa.req = 8'h01;
    tick();
    chk("t2_cyc1", ifa.grant, 8'h01);
    tick();
    chk("t2_cyc2", ifa.grant, 8'h01);
    tick();
    chk("t2_cyc3", ifa.grant, 8'h01);
    ifa.done = 1'b1;
    tick();
    chk("t2_rel", ifa.grant, 8'h00);
    chk("t2_bubble", {7'b0, ifa.grant_valid}, 8'h00);
    ifa.done = 1'b0;
    tick();
    chk("t2_regrant", ifa.grant, 8'h01);

    // Rotation from ptr=0 with all requesting and done held high.
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    ifa.req  = 8'hFF;
    ifa.done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t3_grant", ifa.grant, rot[i]);
      tick();
      chk("t3_bubble", {7'b0, ifa.grant_valid}, 8'h00);
    end

    // Wrap: ptr=1, grant bit 3 then release -> ptr=4.
    ifa.req = 8'h08;
    tick();
    chk("t4_g08", ifa.grant, 8'h08);
    tick();
    chk("t4_rel08", ifa.grant, 8'h00);
    ifa.done = 1'b0;
    ifa.req  = 8'h09;
    tick();
    chk("t4_wrap", ifa.grant, 8'h01);
    ifa.done = 1'b1;
    tick();
    chk("t4_rel01", ifa.grant, 8'h00);
    ifa.done = 1'b0;
    tick();
    chk("t4_next08", ifa.grant, 8'h08);
    ifa.req = 8'h00;
    tick();
    chk("t4_drop", ifa.grant, 8'h00);

    // Requester drop: ptr=4 -> grant 10, drop -> ptr=5.
    ifa.req = 8'h10;
    tick();
    chk("t6_g10", ifa.grant, 8'h10);
    chk("t6_enc4", enc(ifa.grant), 8'h04);
    ifa.req = 8'h00;
    tick();
    chk("t6_rel", ifa.grant, 8'h00);
    chk("t6_no_to", {7'b0, ifa.timeout}, 8'h00);
    chk("t6_enc0", enc(ifa.grant), 8'h00);
    ifa.req = 8'hFF;
    tick();
    chk("t6_ptr5", ifa.grant, 8'h20);
    ifa.req = 8'h00;
    tick();
    chk("t6_idle", ifa.grant, 8'h00);

    // Timeout with MAX_HOLD=4 on dut_b.
    ifb.req = 8'h06;
    tick();
    chk("t5_g02_h0", ifb.grant, 8'h02);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t5_g02_hold", ifb.grant, 8'h02);
      chk("t5_no_to", {7'b0, ifb.timeout}, 8'h00);
    end
    tick();
    chk("t5_to_rel", ifb.grant, 8'h00);
    chk("t5_to_pulse", {7'b0, ifb.timeout}, 8'h01);
    tick();
    chk("t5_g04", ifb.grant, 8'h04);
    chk("t5_to_clear", {7'b0, ifb.timeout}, 8'h00);
    tick();
    tick();
    tick();
    chk("t5_g04_h3", ifb.grant, 8'h04);
    ifb.done = 1'b1;
    tick();
    chk("t5_done_rel", ifb.grant, 8'h00);
    chk("t5_done_no_to", {7'b0, ifb.timeout}, 8'h00);
    ifb.done = 1'b0;
    ifb.req  = 8'h00;
    tick();
    chk("t5_idle", ifb.grant, 8'h00);
    chk("t5_idle_to", {7'b0, ifb.timeout}, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
